// File: rtl/ram_bank_if.sv
// Bus-side connection of the RAM bank: shared tri-state data bus plus the
// controller's MI/MINC/RO/RI control lines.
interface ram_bank_if #(
    parameter int unsigned DATA_W = 8
);
    wire  [DATA_W-1:0] bus;
    logic              MI;
    logic              MINC;
    logic              RO;
    logic              RI;

    modport master (
        inout  bus,
        output MI,
        output MINC,
        output RO,
        output RI
    );

    modport slave (
        inout  bus,
        input  MI,
        input  MINC,
        input  RO,
        input  RI
    );
endinterface

// File: rtl/ram_bank.sv
// Synchronous RAM with its own memory address register on the shared bus.
// After reset a sweep zeroes every word, the MAR can auto-increment, and a
// program mode loads words from front-panel switches.
module ram_bank #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 4,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              clr,
    ram_bank_if.slave         io,
    input  logic              prog,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_we,
    output logic              busy,
    output logic [ADDR_W-1:0] mar_out
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_PROG
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] mar;
    logic [ADDR_W-1:0] mar_nxt;
    logic [ADDR_W-1:0] sweep_cnt;
    logic [DATA_W-1:0] rdata;
    logic              prog_we_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              bus_oe;

    // Next state, next MAR and the single memory write port selection.
    always_comb begin
        state_nxt = state;
        mar_nxt   = mar;
        mem_we    = 1'b0;
        mem_waddr = mar;
        mem_wdata = io.bus;
        case (state)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_cnt;
                mem_wdata = '0;
                if (sweep_cnt == LAST_ADDR) begin
                    state_nxt = prog ? ST_PROG : ST_RUN;
                end
            end
            ST_RUN: begin
                if (io.MI) begin
                    mar_nxt = io.bus[ADDR_W-1:0];
                end else if (io.MINC) begin
                    mar_nxt = mar + 1'b1;
                end
                // Never write back our own bus output.
                if (io.RI && !io.RO) begin
                    mem_we = 1'b1;
                end
                if (prog) begin
                    state_nxt = ST_PROG;
                end
            end
            ST_PROG: begin
                mar_nxt = prog_addr;
                if (prog_we && !prog_we_q) begin
                    mem_we    = 1'b1;
                    mem_waddr = prog_addr;
                    mem_wdata = prog_data;
                end
                if (!prog) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase
    end

    // Control state: FSM, MAR, sweep counter, read register, button history.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            mar       <= '0;
            sweep_cnt <= '0;
            rdata     <= '0;
            prog_we_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            mar       <= mar_nxt;
            prog_we_q <= prog_we;
            if (state == ST_CLEAR) begin
                sweep_cnt <= sweep_cnt + 1'b1;
            end else begin
                rdata <= mem[mar];
            end
        end
    end

    // Memory array; reset never touches it, so writes are blocked while clr is low.
    always_ff @(posedge clk) begin
        if (mem_we && clr) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus_oe  = (state == ST_RUN) && io.RO;
    assign io.bus  = bus_oe ? rdata : 'z;
    assign busy    = (state == ST_CLEAR);
    assign mar_out = mar;
endmodule

// File: tb/tb_ram_bank.sv
// Scoreboard bench for ram_bank: expected read words are queued when a read
// is launched and popped when the word appears on the bus.
module tb_ram_bank;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              clr = 1'b0;
    logic              prog = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [DATA_W-1:0] prog_data = '0;
    logic              prog_we = 1'b0;
    logic              busy;
    logic [ADDR_W-1:0] mar_out;

    logic              drv_en = 1'b0;
    logic [DATA_W-1:0] drv_val = '0;

    int checks = 0;
    int fails  = 0;

    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    ram_bank_if #(.DATA_W(DATA_W)) ifc ();

    assign ifc.bus = drv_en ? drv_val : 'z;

    ram_bank #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .clr(clr),
        .io(ifc),
        .prog(prog),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .prog_we(prog_we),
        .busy(busy),
        .mar_out(mar_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_drive(input logic [DATA_W-1:0] v);
        drv_en  = 1'b1;
        drv_val = v;
    endtask

    task automatic bus_release();
        drv_en = 1'b0;
    endtask

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ifc.MI = 1'b1;
        bus_drive(DATA_W'(a));
        step();
        ifc.MI = 1'b0;
        ifc.RI = 1'b1;
        bus_drive(d);
        step();
        ifc.RI = 1'b0;
        bus_release();
        model[a] = d;
    endtask

    // MI at edge N, rdata valid after N+1; expected word queued here.
    task automatic start_read(input logic [ADDR_W-1:0] a);
        ifc.MI = 1'b1;
        bus_drive(DATA_W'(a));
        step();
        ifc.MI = 1'b0;
        bus_release();
        step();
        exp_q.push_back(model[a]);
    endtask

    task automatic sample_bus(output logic [DATA_W-1:0] got);
        ifc.RO = 1'b1;
        #1;
        got = ifc.bus;
        ifc.RO = 1'b0;
        #1;
    endtask

    task automatic wait_sweep(output int n);
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        clr = 1'b0;
        step();
        step();
        checks++;
        if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b expected 1", busy); end
        checks++;
        if (mar_out !== '0) begin fails++; $display("FAIL reset_mar: got %h expected 0", mar_out); end
        clr = 1'b1;
        wait_sweep(n);
        checks++;
        if (n != 16) begin fails++; $display("FAIL sweep_len: got %0d edges expected 16", n); end
        model_zero();
    endtask

    task automatic test_clear_after_reset();
        int n;
        logic [DATA_W-1:0] got, exp;
        do_write(4'd5, 8'hA5);
        start_read(4'd5);
        sample_bus(got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin fails++; $display("FAIL preload_read: got %h expected %h", got, exp); end
        clr = 1'b0;
        #1;
        checks++;
        if (mar_out !== '0) begin fails++; $display("FAIL async_mar_clear: got %h expected 0", mar_out); end
        checks++;
        if (busy !== 1'b1) begin fails++; $display("FAIL async_busy: got %b expected 1", busy); end
        step();
        clr = 1'b1;
        wait_sweep(n);
        checks++;
        if (n != 16) begin fails++; $display("FAIL resweep_len: got %0d edges expected 16", n); end
        model_zero();
        start_read(4'd5);
        sample_bus(got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin fails++; $display("FAIL cleared_word: got %h expected %h", got, exp); end
    endtask

    task automatic test_run_rw();
        logic [DATA_W-1:0] got, exp;
        do_write(4'd3, 8'h5C);
        start_read(4'd3);
        sample_bus(got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin fails++; $display("FAIL run_read: got %h expected %h", got, exp); end
        // RO low: the bus must not carry the read word.
        got = ifc.bus;
        checks++;
        if (got === 8'h5C) begin fails++; $display("FAIL bus_float_ro0: got %h expected undriven", got); end
    endtask

    task automatic test_mar();
        ifc.MI = 1'b1;
        bus_drive(8'd15);
        step();
        ifc.MI = 1'b0;
        bus_release();
        checks++;
        if (mar_out !== 4'd15) begin fails++; $display("FAIL mar_load: got %h expected f", mar_out); end
        ifc.MINC = 1'b1;
        step();
        checks++;
        if (mar_out !== 4'd0) begin fails++; $display("FAIL mar_wrap: got %h expected 0", mar_out); end
        ifc.MI = 1'b1;
        bus_drive(8'd7);
        step();
        ifc.MI = 1'b0;
        bus_release();
        checks++;
        if (mar_out !== 4'd7) begin fails++; $display("FAIL mi_priority: got %h expected 7", mar_out); end
        step();
        ifc.MINC = 1'b0;
        checks++;
        if (mar_out !== 4'd8) begin fails++; $display("FAIL mar_inc: got %h expected 8", mar_out); end
    endtask

    task automatic test_prog();
        logic [DATA_W-1:0] got, exp;
        prog      = 1'b1;
        prog_addr = 4'd9;
        prog_data = 8'h3E;
        prog_we   = 1'b0;
        step();
        step();
        prog_we = 1'b1;
        repeat (5) step();
        checks++;
        if (mar_out !== 4'd9) begin fails++; $display("FAIL prog_mar: got %h expected 9", mar_out); end
        prog_data = 8'h41;
        step();
        step();
        ifc.RO = 1'b1;
        #1;
        got = ifc.bus;
        ifc.RO = 1'b0;
        checks++;
        if (got === 8'h3E) begin fails++; $display("FAIL prog_bus_float: got %h expected undriven", got); end
        prog_we = 1'b0;
        prog    = 1'b0;
        step();
        model[9] = 8'h3E;
        start_read(4'd9);
        sample_bus(got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin fails++; $display("FAIL prog_once: got %h expected %h", got, exp); end
        // Button already held when entering program mode must not write.
        prog_data = 8'h66;
        prog_we   = 1'b1;
        step();
        prog = 1'b1;
        step();
        step();
        step();
        prog    = 1'b0;
        prog_we = 1'b0;
        step();
        start_read(4'd9);
        sample_bus(got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin fails++; $display("FAIL held_button: got %h expected %h", got, exp); end
    endtask

    task automatic test_same_edge();
        logic [DATA_W-1:0] got, exp;
        do_write(4'd3, 8'h77);
        do_write(4'd2, 8'h11);
        step();
        exp_q.push_back(model[2]);
        ifc.RI = 1'b1;
        bus_drive(8'h22);
        step();
        ifc.RI = 1'b0;
        bus_release();
        model[2] = 8'h22;
        exp_q.push_back(model[2]);
        ifc.RO = 1'b1;
        #1;
        got = ifc.bus;
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin fails++; $display("FAIL read_first: got %h expected %h", got, exp); end
        step();
        got = ifc.bus;
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin fails++; $display("FAIL write_visible: got %h expected %h", got, exp); end
        ifc.RO = 1'b0;
        // rdata holds mem[3] while MAR points at 2, so a bad RI+RO write is visible.
        ifc.MI = 1'b1;
        bus_drive(8'd3);
        step();
        ifc.MI = 1'b0;
        bus_release();
        step();
        ifc.MI = 1'b1;
        bus_drive(8'd2);
        step();
        ifc.MI = 1'b0;
        bus_release();
        ifc.RO = 1'b1;
        ifc.RI = 1'b1;
        step();
        ifc.RO = 1'b0;
        ifc.RI = 1'b0;
        start_read(4'd2);
        sample_bus(got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin fails++; $display("FAIL ri_with_ro: got %h expected %h", got, exp); end
    endtask

    task automatic test_midsweep();
        int n;
        logic [DATA_W-1:0] got, exp;
        clr = 1'b0;
        step();
        clr = 1'b1;
        repeat (7) step();
        checks++;
        if (busy !== 1'b1) begin fails++; $display("FAIL midsweep_busy: got %b expected 1", busy); end
        clr = 1'b0;
        step();
        clr = 1'b1;
        wait_sweep(n);
        checks++;
        if (n != 16) begin fails++; $display("FAIL midsweep_restart: got %0d edges expected 16", n); end
        model_zero();
        start_read(4'd3);
        sample_bus(got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin fails++; $display("FAIL midsweep_word: got %h expected %h", got, exp); end
    endtask

    initial begin
        ifc.MI   = 1'b0;
        ifc.MINC = 1'b0;
        ifc.RO   = 1'b0;
        ifc.RI   = 1'b0;
        model_zero();
        test_reset();
        test_clear_after_reset();
        test_run_rw();
        test_mar();
        test_prog();
        test_same_edge();
        test_midsweep();
        checks++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
